// File: rtl/eth_ff_pkg.sv
// Shared definitions for the Ethernet frame former.
//   state_t        : frame former FSM states (also driven onto the State debug port)
//   HDR_BYTES      : header length in bytes (dest MAC, src MAC, Link_Type, SyncWord)
//   *_OFF          : byte offsets of the header fields within the frame
//   popcount_keep  : number of set bits in a (zero-extended) keep vector
//   keep_mask      : keep vector with the n low bits set
//   build_header   : assembles the 16 header bytes, byte 0 in bits [7:0]
package eth_ff_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      HDR  = 3'd1,
      PAY  = 3'd2,
      PAD  = 3'd3,
      DROP = 3'd4
   } state_t;

   localparam int unsigned HDR_BYTES = 16;
   localparam int unsigned DST_OFF   = 0;
   localparam int unsigned SRC_OFF   = 6;
   localparam int unsigned TYPE_OFF  = 12;
   localparam int unsigned SYNC_OFF  = 14;

   function automatic logic [4:0] popcount_keep(input logic [15:0] keep);
      logic [4:0] n;
      n = '0;
      for (int unsigned i = 0; i < 16; i++) begin
         n = n + 5'(keep[i]);
      end
      return n;
   endfunction

   function automatic logic [15:0] keep_mask(input logic [4:0] n);
      logic [16:0] m;
      m = (17'd1 << n) - 17'd1;
      return m[15:0];
   endfunction

   // MAC addresses and 16-bit fields go out most significant byte first.
   function automatic logic [127:0] build_header(input logic [47:0] dst,
                                                 input logic [47:0] src,
                                                 input logic [15:0] ltype,
                                                 input logic [15:0] sync);
      logic [127:0] h;
      h = '0;
      for (int unsigned i = 0; i < 6; i++) begin
         h[8*(DST_OFF+i) +: 8] = dst[8*(5-i) +: 8];
         h[8*(SRC_OFF+i) +: 8] = src[8*(5-i) +: 8];
      end
      h[8*TYPE_OFF     +: 8] = ltype[15:8];
      h[8*(TYPE_OFF+1) +: 8] = ltype[7:0];
      h[8*SYNC_OFF     +: 8] = sync[15:8];
      h[8*(SYNC_OFF+1) +: 8] = sync[7:0];
      return h;
   endfunction

endpackage

// File: rtl/eth_ff_fifo.sv
// Synchronous first-word-fall-through FIFO used to buffer payload beats.
//   clk, rst     : clock, synchronous active-high reset (flushes contents)
//   wr_en/wr_data: push request and data (ignored when full)
//   rd_en/rd_data: pop request; rd_data shows the head entry while not empty
//   full, empty  : occupancy flags
//   level        : number of stored entries (0..DEPTH)
module eth_ff_fifo
   import eth_ff_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      cnt;
   logic             push;
   logic             pop;

   assign full    = (cnt == (AW+1)'(DEPTH));
   assign empty   = (cnt == '0);
   assign push    = wr_en && !full;
   assign pop     = rd_en && !empty;
   assign rd_data = mem[rd_ptr];
   assign level   = cnt;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   cnt <= cnt + (AW+1)'(1);
            2'b01:   cnt <= cnt - (AW+1)'(1);
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/eth_frame_former_v2.sv
// Ethernet frame former: buffers an AXI-Stream payload and prepends a
// 16-byte header (dest MAC, src MAC, Link_Type, SyncWord). Short frames are
// zero-padded up to MIN_FRAME_BYTES, oversize payloads are cut at
// MAX_PAYLOAD_BYTES and the rest of that input frame is discarded.
//   ACLK, ARESET        : clock, synchronous active-high reset
//   S_AXIS_*            : payload input stream (tready = FIFO not full)
//   M_AXIS_*            : registered frame output stream
//   Destination_Address, Source_Address, Link_Type, SyncWord : header fields,
//                         sampled when a frame starts
//   Frame_Count         : frames completed (tlast handshakes)
//   Trunc_Count         : frames truncated at MAX_PAYLOAD_BYTES
//   Fifo_Level          : payload FIFO occupancy
//   State               : FSM state for debug
module eth_frame_former_v2
   import eth_ff_pkg::*;
#(
   parameter int unsigned DATA_WIDTH        = 64,
   parameter int unsigned FIFO_DEPTH        = 64,
   parameter int unsigned PAD_EN            = 1,
   parameter int unsigned MIN_FRAME_BYTES   = 60,
   parameter int unsigned MAX_PAYLOAD_BYTES = 1500
) (
   input  logic                            ACLK,
   input  logic                            ARESET,
   input  logic [DATA_WIDTH-1:0]           S_AXIS_tdata,
   input  logic [DATA_WIDTH/8-1:0]         S_AXIS_tkeep,
   input  logic                            S_AXIS_tvalid,
   input  logic                            S_AXIS_tlast,
   output logic                            S_AXIS_tready,
   output logic [DATA_WIDTH-1:0]           M_AXIS_tdata,
   output logic [DATA_WIDTH/8-1:0]         M_AXIS_tkeep,
   output logic                            M_AXIS_tvalid,
   output logic                            M_AXIS_tlast,
   input  logic                            M_AXIS_tready,
   input  logic [47:0]                     Destination_Address,
   input  logic [47:0]                     Source_Address,
   input  logic [15:0]                     Link_Type,
   input  logic [15:0]                     SyncWord,
   output logic [31:0]                     Frame_Count,
   output logic [15:0]                     Trunc_Count,
   output logic [$clog2(FIFO_DEPTH):0]     Fifo_Level,
   output logic [2:0]                      State
);

   localparam int unsigned KW        = DATA_WIDTH/8;
   localparam int unsigned HDR_BEATS = HDR_BYTES/KW;
   localparam int unsigned FW        = DATA_WIDTH + KW + 1;
   localparam logic [14:0] MAX_L     = 15'(MAX_PAYLOAD_BYTES);
   localparam logic [15:0] MIN_L     = 16'(MIN_FRAME_BYTES);
   localparam logic [15:0] BYTES_L   = 16'(KW);
   localparam logic [15:0] HDR_L     = 16'(HDR_BYTES);

   function automatic logic [DATA_WIDTH-1:0] zero_unkept(input logic [DATA_WIDTH-1:0] d,
                                                         input logic [KW-1:0] k);
      logic [DATA_WIDTH-1:0] r;
      for (int unsigned b = 0; b < KW; b++) begin
         r[8*b +: 8] = k[b] ? d[8*b +: 8] : 8'h00;
      end
      return r;
   endfunction

   // FIFO
   logic                  fifo_wr;
   logic                  fifo_rd;
   logic [FW-1:0]         fifo_din;
   logic [FW-1:0]         fifo_dout;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [DATA_WIDTH-1:0] f_data;
   logic [KW-1:0]         f_keep;
   logic                  f_last;

   // state and registered outputs
   state_t                state;
   state_t                state_d;
   logic [127:0]          hdr_q;
   logic                  hdr_idx;
   logic                  hdr_idx_d;
   logic [13:0]           pay_cnt;
   logic [13:0]           pay_cnt_d;
   logic [15:0]           pos;
   logic [15:0]           pos_d;
   logic                  rdy_q;
   logic                  m_valid;
   logic [DATA_WIDTH-1:0] m_data;
   logic [KW-1:0]         m_keep;
   logic                  m_last;
   logic [31:0]           frame_cnt;
   logic [15:0]           trunc_cnt;

   // next-beat values computed by the FSM
   logic                  out_free;
   logic                  load;
   logic [DATA_WIDTH-1:0] ld_data;
   logic [KW-1:0]         ld_keep;
   logic                  ld_last;
   logic                  trunc_inc;
   logic                  latch_hdr;
   logic [4:0]            pc;
   logic [14:0]           new_cnt;
   logic [15:0]           rem;
   logic [15:0]           kmask;

   // rdy_q keeps tready low through reset and for the first edge after it.
   assign S_AXIS_tready = rdy_q && !fifo_full;
   assign fifo_wr       = S_AXIS_tvalid && S_AXIS_tready;
   assign fifo_din      = {S_AXIS_tdata, S_AXIS_tkeep, S_AXIS_tlast};
   assign f_data        = fifo_dout[FW-1 -: DATA_WIDTH];
   assign f_keep        = fifo_dout[KW:1];
   assign f_last        = fifo_dout[0];

   eth_ff_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (ACLK),
      .rst     (ARESET),
      .wr_en   (fifo_wr),
      .wr_data (fifo_din),
      .rd_en   (fifo_rd),
      .rd_data (fifo_dout),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (Fifo_Level)
   );

   assign out_free = !m_valid || M_AXIS_tready;

   always_comb begin
      state_d   = state;
      hdr_idx_d = hdr_idx;
      pay_cnt_d = pay_cnt;
      pos_d     = pos;
      load      = 1'b0;
      ld_data   = '0;
      ld_keep   = '0;
      ld_last   = 1'b0;
      fifo_rd   = 1'b0;
      trunc_inc = 1'b0;
      latch_hdr = 1'b0;
      pc        = popcount_keep(16'(f_keep));
      new_cnt   = {1'b0, pay_cnt} + 15'(pc);
      rem       = MIN_L - pos;
      kmask     = '0;

      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               state_d   = HDR;
               latch_hdr = 1'b1;
               hdr_idx_d = 1'b0;
               pay_cnt_d = '0;
               pos_d     = '0;
            end
         end

         HDR: begin
            if (out_free) begin
               load    = 1'b1;
               ld_keep = '1;
               ld_data = hdr_idx ? hdr_q[127 -: DATA_WIDTH] : hdr_q[DATA_WIDTH-1:0];
               if (HDR_BEATS == 1 || hdr_idx) begin
                  state_d = PAY;
                  pos_d   = HDR_L;
               end else begin
                  hdr_idx_d = 1'b1;
               end
            end
         end

         PAY: begin
            if (out_free && !fifo_empty) begin
               fifo_rd   = 1'b1;
               load      = 1'b1;
               pay_cnt_d = new_cnt[13:0];
               if (f_last) begin
                  if (PAD_EN != 0 && (HDR_L + {1'b0, new_cnt}) < MIN_L) begin
                     ld_data = zero_unkept(f_data, f_keep);
                     // The rounded-up beat may already reach the minimum
                     // frame length; then it closes the frame itself.
                     if (pos + BYTES_L >= MIN_L) begin
                        kmask   = keep_mask(rem[4:0]);
                        ld_keep = kmask[KW-1:0];
                        ld_last = 1'b1;
                        state_d = IDLE;
                     end else begin
                        ld_keep = '1;
                        pos_d   = pos + BYTES_L;
                        state_d = PAD;
                     end
                  end else begin
                     ld_data = f_data;
                     ld_keep = f_keep;
                     ld_last = 1'b1;
                     state_d = IDLE;
                  end
               end else if (new_cnt >= MAX_L) begin
                  kmask     = keep_mask(5'(MAX_L - {1'b0, pay_cnt}));
                  ld_data   = f_data;
                  ld_keep   = kmask[KW-1:0];
                  ld_last   = 1'b1;
                  trunc_inc = 1'b1;
                  state_d   = DROP;
               end else begin
                  ld_data = f_data;
                  ld_keep = f_keep;
                  pos_d   = pos + BYTES_L;
               end
            end
         end

         PAD: begin
            if (out_free) begin
               load = 1'b1;
               if (rem <= BYTES_L) begin
                  kmask   = keep_mask(rem[4:0]);
                  ld_keep = kmask[KW-1:0];
                  ld_last = 1'b1;
                  state_d = IDLE;
               end else begin
                  ld_keep = '1;
                  pos_d   = pos + BYTES_L;
               end
            end
         end

         DROP: begin
            if (!fifo_empty) begin
               fifo_rd = 1'b1;
               if (f_last) begin
                  state_d = IDLE;
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state     <= IDLE;
         hdr_q     <= '0;
         hdr_idx   <= 1'b0;
         pay_cnt   <= '0;
         pos       <= '0;
         rdy_q     <= 1'b0;
         m_valid   <= 1'b0;
         m_data    <= '0;
         m_keep    <= '0;
         m_last    <= 1'b0;
         frame_cnt <= '0;
         trunc_cnt <= '0;
      end else begin
         state   <= state_d;
         hdr_idx <= hdr_idx_d;
         pay_cnt <= pay_cnt_d;
         pos     <= pos_d;
         rdy_q   <= 1'b1;
         if (latch_hdr) begin
            hdr_q <= build_header(Destination_Address, Source_Address, Link_Type, SyncWord);
         end
         if (out_free) begin
            m_valid <= load;
            m_data  <= ld_data;
            m_keep  <= ld_keep;
            m_last  <= ld_last;
         end
         if (m_valid && M_AXIS_tready && m_last) begin
            frame_cnt <= frame_cnt + 32'd1;
         end
         if (trunc_inc) begin
            trunc_cnt <= trunc_cnt + 16'd1;
         end
      end
   end

   assign M_AXIS_tvalid = m_valid;
   assign M_AXIS_tdata  = m_data;
   assign M_AXIS_tkeep  = m_keep;
   assign M_AXIS_tlast  = m_last;
   assign Frame_Count   = frame_cnt;
   assign Trunc_Count   = trunc_cnt;
   assign State         = state;

endmodule
